// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master engine with per-frame CPOL/CPHA, SCLK divider,
// bit order and chip-select index. A multi-word frame keeps its chip select
// low until the word flagged tx_last has been shifted.
// Build option SPI_MISO_SYNC_EN: MISO passes through a 2-FF synchroniser and
// each sample is taken 2 clk cycles after its SCLK edge (needs cfg_div >= 2).
module spi_master_multi #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned DIV_W  = 16,
  localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [CS_W-1:0]   cfg_cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_clk,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned NEDGE = 2 * DATA_W;
  localparam int unsigned EC_W  = $clog2(NEDGE + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    WAIT,
    HOLD,
    GAP
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [EC_W-1:0]     edge_q;
  logic                cpha_q;
  logic                lsb_q;
  logic [DIV_W-1:0]    div_q;
  logic                last_q;
  logic [DATA_W-1:0]   tx_sh_q;
  logic [DATA_W-1:0]   rx_sh_q;
  logic                spi_clk_q;
  logic [NUM_CS-1:0]   spi_cs_n_q;
  logic                spi_mosi_q;
  logic                tx_ready_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                busy_q;

  logic                accept_c;
  logic                tick_c;
  logic                edge_fire_c;
  logic [EC_W-1:0]     edge_d;
  logic                odd_c;
  logic                final_c;
  logic                sample_edge_c;
  logic                shift_edge_c;
  logic                done_edge_c;
  logic                samp_c;
  logic                samp_bit_c;
  logic                done_c;
  logic [DATA_W-1:0]   rx_sh_d;
  logic [NUM_CS-1:0]   cs_dec_c;

  // Bit presented next on MOSI for the chosen ordering.
  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  // Drop the bit just presented on MOSI.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d,
                                                  input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  // Insert a sampled MISO bit so the word assembles in transmit order.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] d,
                                                 input logic b, input logic lsb);
    return lsb ? {b, d[DATA_W-1:1]} : {d[DATA_W-2:0], b};
  endfunction

  // Edge bookkeeping: which SCLK edge fires now and what it does.
  always_comb begin
    accept_c      = tx_valid && tx_ready_q;
    tick_c        = (cnt_q == '0);
    edge_fire_c   = tick_c && ((state_q == SETUP) || (state_q == SHIFT));
    edge_d        = edge_q + EC_W'(1);
    odd_c         = edge_d[0];
    final_c       = (edge_d == EC_W'(NEDGE));
    sample_edge_c = edge_fire_c && (cpha_q ? !odd_c : odd_c);
    shift_edge_c  = edge_fire_c && (cpha_q ? odd_c : (!odd_c && !final_c));
    done_edge_c   = edge_fire_c && final_c;
  end

  // One-hot active-low decode of the requested chip select; out of range selects none.
  always_comb begin
    cs_dec_c = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cfg_cs_sel == CS_W'(i)) cs_dec_c[i] = 1'b0;
    end
  end

`ifdef SPI_MISO_SYNC_EN
  logic       miso_s1_q;
  logic       miso_s2_q;
  logic [1:0] samp_pipe_q;
  logic [1:0] done_pipe_q;

  // MISO synchroniser plus matching 2-cycle delay of sample/done strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      samp_pipe_q <= '0;
      done_pipe_q <= '0;
    end else begin
      miso_s1_q   <= spi_miso;
      miso_s2_q   <= miso_s1_q;
      samp_pipe_q <= {samp_pipe_q[0], sample_edge_c};
      done_pipe_q <= {done_pipe_q[0], done_edge_c};
    end
  end

  assign samp_c     = samp_pipe_q[1];
  assign samp_bit_c = miso_s2_q;
  assign done_c     = done_pipe_q[1];
`else
  assign samp_c     = sample_edge_c;
  assign samp_bit_c = spi_miso;
  assign done_c     = done_edge_c;
`endif

  // Receive shift register next value.
  always_comb begin
    rx_sh_d = rx_sh_q;
    if (samp_c) rx_sh_d = shift_in(rx_sh_q, samp_bit_c, lsb_q);
  end

  // Frame FSM with registered pad and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      div_q      <= '0;
      last_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      spi_clk_q  <= 1'b0;
      spi_cs_n_q <= '1;
      spi_mosi_q <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_sh_q    <= rx_sh_d;
      if (done_c) begin
        rx_data_q  <= rx_sh_d;
        rx_valid_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          spi_clk_q  <= cfg_cpol;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept_c) begin
            cpha_q     <= cfg_cpha;
            lsb_q      <= cfg_lsb_first;
            div_q      <= cfg_div;
            last_q     <= tx_last;
            cnt_q      <= cfg_div;
            edge_q     <= '0;
            spi_cs_n_q <= cs_dec_c;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (!cfg_cpha) begin
              spi_mosi_q <= first_bit(tx_data, cfg_lsb_first);
              tx_sh_q    <= shift_out(tx_data, cfg_lsb_first);
            end else begin
              tx_sh_q    <= tx_data;
            end
            state_q <= SETUP;
          end
        end

        // SETUP's tick is the first SCLK edge, so CS leads it by one half-period.
        SETUP, SHIFT: begin
          if (!tick_c) begin
            cnt_q <= cnt_q - DIV_W'(1);
          end else begin
            cnt_q     <= div_q;
            spi_clk_q <= ~spi_clk_q;
            edge_q    <= edge_d;
            if (shift_edge_c) begin
              spi_mosi_q <= first_bit(tx_sh_q, lsb_q);
              tx_sh_q    <= shift_out(tx_sh_q, lsb_q);
            end
            if (final_c) begin
              state_q    <= last_q ? HOLD : WAIT;
              tx_ready_q <= !last_q;
            end else begin
              state_q <= SHIFT;
            end
          end
        end

        WAIT: begin
          if (accept_c) begin
            last_q     <= tx_last;
            cnt_q      <= div_q;
            edge_q     <= '0;
            tx_ready_q <= 1'b0;
            if (!cpha_q) begin
              spi_mosi_q <= first_bit(tx_data, lsb_q);
              tx_sh_q    <= shift_out(tx_data, lsb_q);
            end else begin
              tx_sh_q    <= tx_data;
            end
            state_q <= SHIFT;
          end
        end

        HOLD: begin
          if (!tick_c) begin
            cnt_q <= cnt_q - DIV_W'(1);
          end else begin
            cnt_q      <= div_q;
            spi_cs_n_q <= '1;
            state_q    <= GAP;
          end
        end

        GAP: begin
          if (!tick_c) begin
            cnt_q <= cnt_q - DIV_W'(1);
          end else begin
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign spi_clk  = spi_clk_q;
  assign spi_cs_n = spi_cs_n_q;
  assign spi_mosi = spi_mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: an 8-bit, 3-CS instance with a
// behavioural SPI slave, plus a 16-bit instance with MISO looped to MOSI.
module tb_spi_master_multi;

  logic        clk;
  logic        rst;
  logic        cpol;
  logic        cpha;
  logic        lsb;
  logic [15:0] div;
  logic [1:0]  cs_sel;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;
  logic        spi_clk;
  logic [2:0]  spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  logic [15:0] b_tx;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_rx_data;
  logic        b_rx_valid;
  logic        b_busy;
  logic        b_spi_clk;
  logic        b_cs_n;
  logic        b_mosi;
  logic        b_miso;

  int          errors;
  int          checks;
  logic [2:0]  exp_cs;

  spi_master_multi #(.DATA_W(8), .NUM_CS(3), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_cpol(cpol), .cfg_cpha(cpha), .cfg_lsb_first(lsb),
    .cfg_div(div), .cfg_cs_sel(cs_sel), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  assign b_miso = b_mosi;

  spi_master_multi #(.DATA_W(16), .NUM_CS(1), .DIV_W(16)) dut16 (
    .clk(clk), .rst(rst), .cfg_cpol(cpol), .cfg_cpha(cpha), .cfg_lsb_first(lsb),
    .cfg_div(div), .cfg_cs_sel(1'b0), .tx_data(b_tx), .tx_last(1'b1),
    .tx_valid(b_valid), .tx_ready(b_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .busy(b_busy), .spi_clk(b_spi_clk), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi),
    .spi_miso(b_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word on the 8-bit instance and wait for its handshake.
  task automatic send(input logic [7:0] w, input logic last, output int ok);
    logic acc;
    tx_data  = w;
    tx_last  = last;
    tx_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      acc = tx_ready;
      tick();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    tx_valid = 1'b0;
  endtask

  // Send one word while acting as the SPI slave: return the MOSI word seen,
  // the rx_data delivered, edge count, rx_valid pulses and edge timing.
  task automatic run_word(input logic [7:0] w, input logic last, input logic [7:0] sw,
                          output logic [7:0] mo, output logic [7:0] rx, output int edges,
                          output int nval, output int t_first, output int gmax,
                          output int csbad);
    int   k;
    int   ok;
    int   t;
    int   tl;
    logic prev;
    logic odd;
    mo = '0; rx = '0; edges = 0; nval = 0; t_first = -1; gmax = 0; csbad = 0;
    k = 0; t = 0; tl = 0;
    spi_miso = lsb ? sw[0] : sw[7];
    send(w, last, ok);
    chk("handshake", ok, 1);
    prev = spi_clk;
    for (int i = 0; i < 400; i++) begin
      tick();
      t++;
      if (spi_cs_n !== exp_cs) csbad++;
      if (rx_valid === 1'b1) begin
        nval++;
        rx = rx_data;
      end
      if (spi_clk !== prev) begin
        prev = spi_clk;
        edges++;
        if (edges == 1) t_first = t;
        else if (t - tl > gmax) gmax = t - tl;
        tl = t;
        odd = ((edges % 2) == 1);
        if (cpha ? !odd : odd) mo = lsb ? {spi_mosi, mo[7:1]} : {mo[6:0], spi_mosi};
        if (cpha ? (odd && edges > 1) : (!odd && edges < 16)) begin
          k++;
          spi_miso = lsb ? sw[k] : sw[7-k];
        end
      end
      if (edges >= 16 && nval > 0) break;
    end
  endtask

  // Closing of a frame: CS hold after the last edge, then the gap until idle.
  task automatic finish_frame(input string tag, input int exp_hold, input int exp_gap);
    int t;
    int xv;
    t = 0; xv = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      t++;
      if (rx_valid === 1'b1) xv++;
      if (spi_cs_n === 3'b111) break;
    end
    chk({tag, "_cs_hold"}, t, exp_hold);
    chk({tag, "_extra_valid"}, xv, 0);
    t = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) break;
      tick();
      t++;
    end
    chk({tag, "_gap"}, t, exp_gap);
    chk({tag, "_ready_idle"}, 32'(tx_ready), 1);
  endtask

  initial begin
    logic [7:0]  mo;
    logic [7:0]  rx;
    logic [15:0] rx16;
    int          ed;
    int          nv;
    int          tf;
    int          gmax;
    int          cb;
    int          viol;
    int          ok;
    logic        acc;
    logic        prev;

    errors = 0; checks = 0;
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; div = 16'd1; cs_sel = 2'd0;
    tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b0; spi_miso = 1'b0;
    b_tx = 16'h0000; b_valid = 1'b0; exp_cs = 3'b111;

    // Reset state
    repeat (3) tick();
    chk("rst_clk", 32'(spi_clk), 0);
    chk("rst_cs", 32'(spi_cs_n), 32'h7);
    chk("rst_mosi", 32'(spi_mosi), 0);
    chk("rst_ready", 32'(tx_ready), 0);
    chk("rst_rxv", 32'(rx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rxdata", 32'(rx_data), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(tx_ready), 1);

    // Mode 0, div=1, MSB-first, CS0, single word 0xDE, slave returns 0xA5
    exp_cs = 3'b110;
    run_word(8'hDE, 1'b1, 8'hA5, mo, rx, ed, nv, tf, gmax, cb);
    chk("t1_mosi", 32'(mo), 32'hDE);
    chk("t1_rx", 32'(rx), 32'hA5);
    chk("t1_edges", ed, 16);
    chk("t1_valids", nv, 1);
    chk("t1_cs_lead", tf, 2);
    chk("t1_half_period", gmax, 2);
    chk("t1_cs_only0", cb, 0);
    finish_frame("t1", 2, 2);

    // 16-bit instance, LSB-first, MISO looped to MOSI
    lsb = 1'b1; cpha = 1'b0; cpol = 1'b0; div = 16'd1;
    b_tx = 16'h1234; b_valid = 1'b1; ok = 0;
    for (int i = 0; i < 100; i++) begin
      acc = b_ready;
      tick();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    b_valid = 1'b0;
    chk("t3_handshake", ok, 1);
    chk("t3_first_mosi", 32'(b_mosi), 0);
    chk("t3_cs", 32'(b_cs_n), 0);
    nv = 0; rx16 = '0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (b_rx_valid === 1'b1) begin
        nv++;
        rx16 = b_rx_data;
        break;
      end
    end
    chk("t3_valid", nv, 1);
    chk("t3_rx", 32'(rx16), 32'h1234);
    tick();
    chk("t3_valid_pulse", 32'(b_rx_valid), 0);
    for (int i = 0; i < 100; i++) begin
      if (b_busy === 1'b0) break;
      tick();
    end
    chk("t3_idle", 32'(b_busy), 0);

    // Mode 3, div=0, 3-word frame on CS2
    cpol = 1'b1; cpha = 1'b1; lsb = 1'b0; div = 16'd0; cs_sel = 2'd2; exp_cs = 3'b011;
    tick(); tick();
    chk("t2_idle_clk", 32'(spi_clk), 1);
    run_word(8'hDE, 1'b0, 8'hA5, mo, rx, ed, nv, tf, gmax, cb);
    chk("t2_w0_mosi", 32'(mo), 32'hDE);
    chk("t2_w0_rx", 32'(rx), 32'hA5);
    chk("t2_w0_edges", ed, 16);
    chk("t2_w0_valids", nv, 1);
    chk("t2_w0_lead", tf, 1);
    chk("t2_w0_half", gmax, 1);
    chk("t2_w0_cs", cb, 0);
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (spi_clk !== 1'b1 || spi_cs_n !== 3'b011 || tx_ready !== 1'b1 || rx_valid !== 1'b0)
        viol++;
    end
    chk("t2_between0", viol, 0);
    run_word(8'hDD, 1'b0, 8'h5A, mo, rx, ed, nv, tf, gmax, cb);
    chk("t2_w1_mosi", 32'(mo), 32'hDD);
    chk("t2_w1_rx", 32'(rx), 32'h5A);
    chk("t2_w1_valids", nv, 1);
    chk("t2_w1_lead", tf, 1);
    chk("t2_w1_cs", cb, 0);
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (spi_clk !== 1'b1 || spi_cs_n !== 3'b011 || tx_ready !== 1'b1 || rx_valid !== 1'b0)
        viol++;
    end
    chk("t2_between1", viol, 0);
    run_word(8'hDC, 1'b1, 8'hB6, mo, rx, ed, nv, tf, gmax, cb);
    chk("t2_w2_mosi", 32'(mo), 32'hDC);
    chk("t2_w2_rx", 32'(rx), 32'hB6);
    chk("t2_w2_edges", ed, 16);
    chk("t2_w2_cs", cb, 0);
    finish_frame("t2", 1, 1);

    // Stall of 50 cycles between two words of a frame on CS1
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; div = 16'd1; cs_sel = 2'd1; exp_cs = 3'b101;
    tick(); tick();
    chk("t4_idle_clk", 32'(spi_clk), 0);
    run_word(8'h3C, 1'b0, 8'h81, mo, rx, ed, nv, tf, gmax, cb);
    chk("t4_w0_mosi", 32'(mo), 32'h3C);
    chk("t4_w0_rx", 32'(rx), 32'h81);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (spi_cs_n !== 3'b101 || spi_clk !== 1'b0 || tx_ready !== 1'b1 || rx_valid !== 1'b0)
        viol++;
    end
    chk("t4_stall", viol, 0);
    run_word(8'hC3, 1'b1, 8'h7E, mo, rx, ed, nv, tf, gmax, cb);
    chk("t4_w1_mosi", 32'(mo), 32'hC3);
    chk("t4_w1_rx", 32'(rx), 32'h7E);
    chk("t4_w1_valids", nv, 1);
    chk("t4_w1_cs", cb, 0);
    finish_frame("t4", 2, 2);

    // Reset at SCLK edge 5, then a clean frame
    cs_sel = 2'd0; exp_cs = 3'b110; spi_miso = 1'b1;
    send(8'h55, 1'b1, ok);
    chk("t5_handshake", ok, 1);
    ed = 0;
    prev = spi_clk;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (spi_clk !== prev) begin
        prev = spi_clk;
        ed++;
      end
      if (ed == 5) break;
    end
    chk("t5_edge5", ed, 5);
    rst = 1'b1;
    tick();
    chk("t5_cs", 32'(spi_cs_n), 32'h7);
    chk("t5_clk", 32'(spi_clk), 0);
    chk("t5_rxv", 32'(rx_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(tx_ready), 0);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rx_valid !== 1'b0) viol++;
    end
    chk("t5_no_valid", viol, 0);
    run_word(8'h96, 1'b1, 8'h69, mo, rx, ed, nv, tf, gmax, cb);
    chk("t5_mosi", 32'(mo), 32'h96);
    chk("t5_rx", 32'(rx), 32'h69);
    chk("t5_valids", nv, 1);
    finish_frame("t5", 2, 2);

    // Out-of-range chip select: no CS asserts, word still clocked
    div = 16'd0; cs_sel = 2'd3; exp_cs = 3'b111;
    run_word(8'hA7, 1'b1, 8'h3B, mo, rx, ed, nv, tf, gmax, cb);
    chk("t6_no_cs", cb, 0);
    chk("t6_edges", ed, 16);
    chk("t6_valids", nv, 1);
    chk("t6_rx", 32'(rx), 32'h3B);
    chk("t6_mosi", 32'(mo), 32'hA7);
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) break;
      tick();
    end
    chk("t6_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
